// File: rtl/ncl_rx_bridge_if.sv
// Handshake bundle between an NCL threshold-gate network and the
// clocked consumer side of ncl_rx_bridge.
interface ncl_rx_bridge_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] rail_t;
  logic [WIDTH-1:0] rail_f;
  logic             ko;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             err;
  logic [7:0]       err_cnt;

  // Environment side: drives the rails and consumes the captured word.
  modport master (
    output rail_t, rail_f, dout_ready,
    input  ko, dout, dout_valid, err, err_cnt
  );

  // Bridge side.
  modport slave (
    input  rail_t, rail_f, dout_ready,
    output ko, dout, dout_valid, err, err_cnt
  );
endinterface

// File: rtl/ncl_rx_bridge.sv
// Dual-rail NCL to synchronous bridge. Rails are double-synchronised,
// classified, debounced by a stability counter and captured into a
// single-rail output register under a valid/ready handshake. ko is the
// completion acknowledge returned to the asynchronous upstream.
module ncl_rx_bridge #(
  parameter int WIDTH  = 4,
  parameter int STABLE = 2
) (
  input logic            clk,
  input logic            rst,
  ncl_rx_bridge_if.slave bus
);

  typedef enum logic [1:0] {CLS_NULL, CLS_DATA, CLS_ILL, CLS_PART} cls_e;
  typedef enum logic [1:0] {INIT_NULL, WAIT_DATA, WAIT_NULL} state_e;

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  // Rails packed as {true, false}.
  logic [2*WIDTH-1:0] sync1, sync2, prev_s;
  // vld_pipe[1] marks that sync2 holds a real sample rather than the
  // reset zeros, so reset-cleared flops never look like a stable NULL.
  logic [1:0]         vld_pipe;
  logic [3:0]         cnt, cnt_nxt;
  logic               stable;
  cls_e               cls, prev_cls;
  state_e             state, state_nxt;
  logic               capture, ill_entry, ko;
  logic [WIDTH-1:0]   dout;
  logic               dout_valid, err;
  logic [7:0]         err_cnt;

  function automatic cls_e classify(input logic [2*WIDTH-1:0] v);
    logic [WIDTH-1:0] t, f;
    t = v[2*WIDTH-1:WIDTH];
    f = v[WIDTH-1:0];
    if ((t & f) != '0) return CLS_ILL;
    if ((t | f) == '0) return CLS_NULL;
    if (&(t ^ f))      return CLS_DATA;
    return CLS_PART;
  endfunction

  // Two-flop synchroniser plus the sample-valid warm-up pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      prev_s   <= '0;
      vld_pipe <= '0;
    end else begin
      sync1    <= {bus.rail_t, bus.rail_f};
      sync2    <= sync1;
      prev_s   <= sync2;
      vld_pipe <= {vld_pipe[0], 1'b1};
    end
  end

  assign cls      = classify(sync2);
  assign prev_cls = classify(prev_s);

  // Stability count including the current cycle; equal samples imply an
  // equal class, so comparing raw samples covers both conditions.
  always_comb begin
    cnt_nxt = 4'd0;
    if (vld_pipe[1]) begin
      if (sync2 == prev_s) cnt_nxt = (cnt >= STABLE_C) ? STABLE_C : cnt + 4'd1;
      else                 cnt_nxt = 4'd1;
    end
  end

  assign stable    = (cnt_nxt >= STABLE_C);
  assign ill_entry = vld_pipe[1] && (cls == CLS_ILL) && (prev_cls != CLS_ILL);

  // Stability counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt <= 4'd0;
    else     cnt <= cnt_nxt;
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT_NULL;
    else     state <= state_nxt;
  end

  // Next-state, capture strobe and ko.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ko        = 1'b1;
    case (state)
      INIT_NULL: if (stable && cls == CLS_NULL) state_nxt = WAIT_DATA;
      WAIT_DATA: begin
        if (stable && cls == CLS_DATA && (!dout_valid || bus.dout_ready)) begin
          capture   = 1'b1;
          state_nxt = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        ko = 1'b0;
        if (stable && cls == CLS_NULL) state_nxt = WAIT_DATA;
      end
      default:   state_nxt = INIT_NULL;
    endcase
  end

  // Output word register; a capture wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (capture) begin
      dout       <= sync2[2*WIDTH-1:WIDTH];
      dout_valid <= 1'b1;
    end else if (dout_valid && bus.dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Sticky error flag and saturating per-episode illegal-code counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else if (ill_entry) begin
      err <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.ko         = ko;
  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.err        = err;
  assign bus.err_cnt    = err_cnt;

endmodule

// File: tb/tb_ncl_rx_bridge.sv
// Directed bench for ncl_rx_bridge (WIDTH=4, STABLE=2).
module tb_ncl_rx_bridge;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   capt  = 0;
  int   c0;

  ncl_rx_bridge_if #(.WIDTH(4)) bus ();

  ncl_rx_bridge #(.WIDTH(4), .STABLE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycles with an unconsumed word; with dout_ready=1 each capture is one cycle.
  always @(negedge clk) if (bus.dout_valid) capt <= capt + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [3:0] v);
    bus.rail_t = v;
    bus.rail_f = ~v;
  endtask

  task automatic set_null();
    bus.rail_t = 4'b0000;
    bus.rail_f = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    bus.dout_ready = 1'b1;
    set_null();
    tick(2);
    chk("rst_ko", bus.ko, 1);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_errcnt", bus.err_cnt, 0);
    rst = 1'b0;
    tick(6);

    // Basic transfer
    set_data(4'hA);
    tick(3);
    chk("xfer_early_valid", bus.dout_valid, 0);
    chk("xfer_early_ko", bus.ko, 1);
    tick(1);
    chk("xfer_dout", bus.dout, 4'hA);
    chk("xfer_valid", bus.dout_valid, 1);
    chk("xfer_ko", bus.ko, 0);
    tick(1);
    chk("xfer_consumed", bus.dout_valid, 0);
    chk("xfer_dout_hold", bus.dout, 4'hA);
    set_null();
    tick(3);
    chk("null_early_ko", bus.ko, 0);
    tick(1);
    chk("null_ko", bus.ko, 1);

    // Back-pressure
    bus.dout_ready = 1'b0;
    set_data(4'h3);
    tick(4);
    chk("bp_first_dout", bus.dout, 4'h3);
    chk("bp_first_valid", bus.dout_valid, 1);
    set_null();
    tick(4);
    chk("bp_null_ko", bus.ko, 1);
    set_data(4'hC);
    tick(8);
    chk("bp_hold_ko", bus.ko, 1);
    chk("bp_hold_dout", bus.dout, 4'h3);
    chk("bp_hold_valid", bus.dout_valid, 1);
    bus.dout_ready = 1'b1;
    tick(1);
    chk("bp_cap_dout", bus.dout, 4'hC);
    chk("bp_cap_valid", bus.dout_valid, 1);
    chk("bp_cap_ko", bus.ko, 0);
    tick(1);
    chk("bp_drain", bus.dout_valid, 0);
    set_null();
    tick(4);
    chk("bp_end_ko", bus.ko, 1);

    // Glitch during build-up
    c0 = capt;
    set_data(4'h6);
    tick(1);
    bus.rail_f[0] = 1'b0;
    tick(1);
    set_data(4'h6);
    tick(3);
    chk("glitch_no_early", bus.dout_valid, 0);
    chk("glitch_no_early_cnt", capt, c0);
    tick(1);
    chk("glitch_dout", bus.dout, 4'h6);
    chk("glitch_valid", bus.dout_valid, 1);
    set_null();
    tick(4);
    chk("glitch_one_cap", capt, c0 + 1);
    chk("glitch_ko", bus.ko, 1);

    // Partial arrival over three cycles, final word 4'hB
    bus.rail_t = 4'b0001; bus.rail_f = 4'b0000;
    tick(1);
    bus.rail_t = 4'b0011; bus.rail_f = 4'b0100;
    tick(1);
    bus.rail_t = 4'b1011; bus.rail_f = 4'b0100;
    tick(3);
    chk("part_no_early", bus.dout_valid, 0);
    chk("part_no_early_cnt", capt, c0 + 1);
    tick(1);
    chk("part_dout", bus.dout, 4'hB);
    chk("part_valid", bus.dout_valid, 1);
    set_null();
    tick(4);
    chk("part_one_cap", capt, c0 + 2);
    chk("part_ko", bus.ko, 1);
    chk("no_err_yet", bus.err, 0);

    // Illegal code episodes
    c0 = capt;
    for (int ep = 0; ep < 300; ep++) begin
      bus.rail_t = 4'b0001; bus.rail_f = 4'b0001;
      tick(5);
      set_null();
      tick(2);
      if (ep == 0) begin
        chk("ill_err", bus.err, 1);
        chk("ill_cnt1", bus.err_cnt, 1);
      end
      if (ep == 9)   chk("ill_cnt10", bus.err_cnt, 10);
      if (ep == 253) chk("ill_cnt254", bus.err_cnt, 254);
      if (ep == 254) chk("ill_cnt255", bus.err_cnt, 255);
    end
    chk("ill_sat", bus.err_cnt, 255);
    chk("ill_err_sticky", bus.err, 1);
    chk("ill_no_cap", capt, c0);
    chk("ill_ko", bus.ko, 1);

    // Reset in WAIT_NULL with DATA held
    set_data(4'h5);
    tick(4);
    chk("mid_cap", bus.dout, 4'h5);
    chk("mid_ko", bus.ko, 0);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_ko", bus.ko, 1);
    chk("mid_rst_valid", bus.dout_valid, 0);
    chk("mid_rst_dout", bus.dout, 0);
    chk("mid_rst_errcnt", bus.err_cnt, 0);
    c0 = capt;
    tick(10);
    chk("mid_no_cap", capt, c0);
    chk("mid_no_cap_ko", bus.ko, 1);
    chk("mid_no_cap_dout", bus.dout, 0);
    set_null();
    tick(6);
    set_data(4'hE);
    tick(3);
    chk("post_early", bus.dout_valid, 0);
    tick(1);
    chk("post_dout", bus.dout, 4'hE);
    chk("post_valid", bus.dout_valid, 1);
    chk("post_ko", bus.ko, 0);
    tick(1);
    chk("post_one_cap", capt, c0 + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ncl_rx_bridge.md
NCL_RX_BRIDGE -- requirements
Module: ncl_rx_bridge

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of dual-rail NCL bits received.
REQ-002 SHALL have parameter STABLE, default 2, legal range 1-15: consecutive identical synchronised samples required before DATA or NULL is accepted.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock for all state.
REQ-004 SHALL provide rst  in  1  synchronous active-high reset.
REQ-005 SHALL provide rail_t  in  WIDTH  true rails of the NCL word from the upstream threshold-gate network (asynchronous to clk).
REQ-006 SHALL provide rail_f  in  WIDTH  false rails of the same word (asynchronous to clk).
REQ-007 SHALL provide ko  out  1  completion acknowledge to upstream: 1 = request-for-data, 0 = request-for-null.
REQ-008 SHALL provide dout  out  WIDTH  captured single-rail word, where bit i = rail_t[i].
REQ-009 SHALL provide dout_valid  out  1  dout holds an unconsumed word.
REQ-010 SHALL provide dout_ready  in  1  consumer accepts dout when it is high in the same cycle as dout_valid.
REQ-011 SHALL provide err  out  1  sticky flag indicating an illegal code was seen.
REQ-012 SHALL provide err_cnt  out  8  saturating count of illegal-code events.

Function
REQ-013 SHALL pass every rail through a 2-flop synchroniser; all classification uses only the second-stage value S.
REQ-014 SHALL classify S each cycle as one of four classes:
- NULL: all rails 0.
- DATA: every bit has exactly one rail high.
- ILLEGAL: any bit has both rails high.
- PARTIAL: anything else.
REQ-015 SHALL keep a stability counter that increments, saturating at STABLE, while S equals the previous cycle's S and its class is unchanged; any change of S or class reloads the counter to 1.
REQ-016 SHALL implement states INIT_NULL, WAIT_DATA and WAIT_NULL.
REQ-017 In INIT_NULL, ko SHALL be 1; the block moves to WAIT_DATA once NULL has been stable for STABLE cycles; any DATA present in this state is ignored.
REQ-018 In WAIT_DATA, ko SHALL be 1; when DATA has been stable for STABLE cycles and (dout_valid==0 or dout_ready==1), the block SHALL load dout, set dout_valid=1, drive ko=0 and move to WAIT_NULL, all on the same edge.
REQ-019 In WAIT_DATA, if DATA is stable but dout_valid==1 and dout_ready==0, the block SHALL stay in WAIT_DATA with ko=1 (upstream holds DATA as back-pressure) and capture on the first cycle the condition in REQ-018 holds.
REQ-020 In WAIT_NULL, ko SHALL be 0; the block moves to WAIT_DATA with ko=1 once NULL has been stable for STABLE cycles; DATA or PARTIAL samples only restart the stability count.
REQ-021 SHALL clear dout_valid on an edge where dout_valid&dout_ready is high and no capture occurs; on a simultaneous capture and accept, dout SHALL take the new word and dout_valid SHALL remain 1.
REQ-022 Latency: with inputs stable, dout_valid and the ko fall SHALL appear 2+STABLE edges after rails become complete DATA; ko SHALL rise 2+STABLE edges after rails return to NULL.
REQ-023 On entry into ILLEGAL (previous class not ILLEGAL), the block SHALL set err and increment err_cnt, saturating at 255.
REQ-024 ILLEGAL SHALL never be captured; the state is unchanged, and a steady ILLEGAL counts only once.
REQ-025 dout SHALL change only on a capture edge.

Reset
REQ-026 On an edge with rst=1, the block SHALL reset to:
- state INIT_NULL, ko=1;
- dout=0, dout_valid=0;
- err=0, err_cnt=0;
- synchroniser flops and stability counter 0.
REQ-027 Reset asserted mid-handshake, in any state, SHALL discard the pending word; DATA still on the rails after reset SHALL NOT be captured until NULL has been seen per REQ-017.
REQ-028 rst SHALL have priority over every other event in the same cycle.

Verification
REQ-029 Basic transfer (WIDTH=4, STABLE=2, dout_ready=1): after reset, hold NULL for 6 cycles, then drive rail_t=4'b1010 and rail_f=4'b0101 -> dout=4'hA and dout_valid=1, with ko=0, 4 edges later; then drive NULL -> ko=1 4 edges later.
REQ-030 Back-pressure: hold dout_ready=0 with word 4'h3 pending, then present DATA 4'hC and complete the NULL phase -> ko stays 1 and dout stays 4'h3; raise dout_ready -> 4'hC is captured on that edge and dout_valid stays 1.
REQ-031 Glitch and partial input: toggle one rail for a single cycle during a DATA build-up; drive PARTIAL 4 bits arriving over 3 cycles -> exactly one capture occurs, with the final value, and only after STABLE stable cycles.
REQ-032 Illegal code: hold rail_t[0]=rail_f[0]=1 for 5 cycles, release it, then repeat 300 times -> err=1, err_cnt increments once per episode and saturates at 255, and no capture occurs.
REQ-033 Reset mid-handshake: assert rst for 1 cycle in WAIT_NULL while DATA 4'h5 remains on the rails -> ko=1, dout_valid=0 and dout=0 after reset; no capture until NULL is stable, after which the next DATA is captured normally.
